// File: rtl/mux_rr_arbiter_8_pkg.sv
// mux_rr_arbiter_8_pkg: shared state encoding, sizes and onehot-to-index helper
package mux_rr_arbiter_8_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [SEL_W-1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) idx |= oh[i] ? SEL_W'(i) : '0;
    return idx;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_8_rr_pick_8.sv
// rr_pick_8: rotating-priority pick of the first request at or after ptr
module rr_pick_8
  import mux_rr_arbiter_8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic               found,
  output logic [SEL_W-1:0]   win
);
  logic [NUM_REQ-1:0] m;
  logic [NUM_REQ-1:0] r;
  logic [SEL_W-1:0] idx;
  assign m = req & ~excl;
  assign r = NUM_REQ'({m, m} >> ptr);
  assign found = |m;
  assign win = ptr + idx;
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (r[i]) idx = SEL_W'(i);
  end
endmodule

// File: rtl/mux_rr_arbiter_8.sv
// mux_rr_arbiter_8: round-robin arbiter with burst limit driving the 8:1 mux select
module mux_rr_arbiter_8
  import mux_rr_arbiter_8_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [SEL_W-1:0]   sel,
  output logic               owner_chg
);
  state_t state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] own;
  logic [SEL_W-1:0] win;
  logic [NUM_REQ-1:0] excl;
  logic found, own_req, others, hold;
  localparam logic [CNT_W-1:0] CNT_MAX = (MAX_BURST == 0) ? '1 : CNT_W'(MAX_BURST);
  assign own = onehot2idx(gnt);
  assign own_req = (state == GRANT) && req[own];
  assign others = |(req & ~gnt);
  assign hold = own_req && (MAX_BURST == 0 || cnt < CNT_MAX || !others);
  // only a still-requesting owner is excluded, i.e. on a forced release
  assign excl = own_req ? gnt : '0;
  assign gnt_valid = |gnt;
  rr_pick_8 u_pick (.req(req), .ptr(ptr), .excl(excl), .found(found), .win(win));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      sel <= '0;
      owner_chg <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      owner_chg <= 1'b0;
      if (hold) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else if (own_req && !en) begin
        cnt <= cnt;
      end else if (en && found) begin
        gnt <= NUM_REQ'(1) << win;
        sel <= win;
        owner_chg <= 1'b1;
        cnt <= CNT_W'(1);
        ptr <= win + 1'b1;
        state <= GRANT;
      end else begin
        gnt <= '0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter_8.sv
// tb_mux_rr_arbiter_8: directed scenario tests for the round-robin arbiter
module tb_mux_rr_arbiter_8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic gnt_valid;
  logic [2:0] sel;
  logic owner_chg;
  int checks = 0;
  int errors = 0;

  mux_rr_arbiter_8 #(.MAX_BURST(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .gnt(gnt), .gnt_valid(gnt_valid), .sel(sel), .owner_chg(owner_chg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd0 || owner_chg !== 1'b0) begin
      errors++;
      $display("FAIL reset: gnt=%h v=%b sel=%0d chg=%b exp 00/0/0/0", gnt, gnt_valid, sel, owner_chg);
    end
  endtask

  task automatic test_first_grant();
    do_reset();
    en = 1'b1;
    req = 8'h01;
    step();
    checks++;
    if (gnt !== 8'h01 || gnt_valid !== 1'b1 || sel !== 3'd0 || owner_chg !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: gnt=%h v=%b sel=%0d chg=%b exp 01/1/0/1", gnt, gnt_valid, sel, owner_chg);
    end
    req = 8'h00;
    step();
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd0) begin
      errors++;
      $display("FAIL release_idle: gnt=%h v=%b sel=%0d exp 00/0/0", gnt, gnt_valid, sel);
    end
    req = 8'h03;
    step();
    checks++;
    if (gnt !== 8'h02 || sel !== 3'd1 || owner_chg !== 1'b1) begin
      errors++;
      $display("FAIL ptr_advance: gnt=%h sel=%0d chg=%b exp 02/1/1", gnt, sel, owner_chg);
    end
    req = 8'h00;
    step();
    step();
    checks++;
    if (gnt !== 8'h00 || sel !== 3'd1 || owner_chg !== 1'b0) begin
      errors++;
      $display("FAIL sel_hold_idle: gnt=%h sel=%0d chg=%b exp 00/1/0", gnt, sel, owner_chg);
    end
  endtask

  task automatic test_burst_limit();
    logic [7:0] eg;
    logic ec;
    do_reset();
    en = 1'b1;
    req = 8'h81;
    for (int c = 1; c <= 12; c++) begin
      step();
      eg = (c <= 4 || c >= 9) ? 8'h01 : 8'h80;
      ec = (c == 1 || c == 5 || c == 9);
      checks++;
      if (gnt !== eg || owner_chg !== ec || sel !== (eg == 8'h01 ? 3'd0 : 3'd7)) begin
        errors++;
        $display("FAIL burst c%0d: gnt=%h chg=%b sel=%0d exp %h/%b", c, gnt, owner_chg, sel, eg, ec);
      end
    end
  endtask

  task automatic test_single_hold();
    do_reset();
    en = 1'b1;
    req = 8'h10;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (gnt !== 8'h10 || sel !== 3'd4 || owner_chg !== (c == 1)) begin
        errors++;
        $display("FAIL single_hold c%0d: gnt=%h sel=%0d chg=%b exp 10/4/%b", c, gnt, sel, owner_chg, c == 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1;
    req = 8'h08;
    step();
    checks++;
    if (gnt !== 8'h08 || sel !== 3'd3) begin
      errors++;
      $display("FAIL b2b_owner3: gnt=%h sel=%0d exp 08/3", gnt, sel);
    end
    req = 8'h04;
    step();
    checks++;
    if (gnt !== 8'h04 || gnt_valid !== 1'b1 || sel !== 3'd2 || owner_chg !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wrap: gnt=%h v=%b sel=%0d chg=%b exp 04/1/2/1", gnt, gnt_valid, sel, owner_chg);
    end
  endtask

  task automatic test_enable();
    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
        errors++;
        $display("FAIL en_idle c%0d: gnt=%h v=%b exp 00/0", c, gnt, gnt_valid);
      end
    end
    do_reset();
    en = 1'b1;
    req = 8'h20;
    for (int c = 0; c < 4; c++) step();
    req = 8'h60;
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (gnt !== 8'h20 || sel !== 3'd5 || owner_chg !== 1'b0) begin
        errors++;
        $display("FAIL en_retain c%0d: gnt=%h sel=%0d chg=%b exp 20/5/0", c, gnt, sel, owner_chg);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (gnt !== 8'h40 || sel !== 3'd6 || owner_chg !== 1'b1) begin
      errors++;
      $display("FAIL en_handoff: gnt=%h sel=%0d chg=%b exp 40/6/1", gnt, sel, owner_chg);
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd0 || owner_chg !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: gnt=%h v=%b sel=%0d chg=%b exp 00/0/0/0", gnt, gnt_valid, sel, owner_chg);
    end
    req = 8'hFF;
    en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (gnt !== 8'h01 || sel !== 3'd0 || owner_chg !== 1'b1) begin
      errors++;
      $display("FAIL restart_ptr0: gnt=%h sel=%0d chg=%b exp 01/0/1", gnt, sel, owner_chg);
    end
    step();
    checks++;
    if (gnt !== 8'h01 || owner_chg !== 1'b0) begin
      errors++;
      $display("FAIL restart_hold: gnt=%h chg=%b exp 01/0", gnt, owner_chg);
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_burst_limit();
    test_single_hold();
    test_back_to_back();
    test_enable();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
